// File: rtl/combined_counter_decoder.sv
// Purpose: decode Johnson/ring counter codes, track sequence lock, count errors.
// Latency: all outputs registered, one cycle after the sampling edge.
// Backpressure: none; code_in is sampled on every cycle with code_valid high.
module combined_counter_decoder #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [4:0]       code_in,
  input  logic             code_valid,
  output logic [3:0]       index,
  output logic             index_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             illegal,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  logic [1:0] state, state_n;
  logic [4:0] expected, expected_n;
  logic [3:0] match_cnt, match_n;
  logic [1:0] miss_cnt, miss_n;
  logic       mode_q;
  logic       mode_chg;

  logic       legal;
  logic [3:0] dec_idx;
  logic [4:0] succ;

  logic [3:0] index_n;
  logic       index_valid_n;
  logic       seq_err_n;
  logic       illegal_n;
  logic       err_inc;

  // Registered copy of mode; any difference flags a family switch this cycle.
  assign mode_chg = mode ^ mode_q;

  // Classify code_in under the current family and compute its successor.
  always_comb begin
    legal   = 1'b0;
    dec_idx = 4'd0;
    if (!mode) begin
      succ = {~code_in[0], code_in[4:1]};
      case (code_in)
        5'b00000: begin legal = 1'b1; dec_idx = 4'd0; end
        5'b10000: begin legal = 1'b1; dec_idx = 4'd1; end
        5'b11000: begin legal = 1'b1; dec_idx = 4'd2; end
        5'b11100: begin legal = 1'b1; dec_idx = 4'd3; end
        5'b11110: begin legal = 1'b1; dec_idx = 4'd4; end
        5'b11111: begin legal = 1'b1; dec_idx = 4'd5; end
        5'b01111: begin legal = 1'b1; dec_idx = 4'd6; end
        5'b00111: begin legal = 1'b1; dec_idx = 4'd7; end
        5'b00011: begin legal = 1'b1; dec_idx = 4'd8; end
        5'b00001: begin legal = 1'b1; dec_idx = 4'd9; end
        default:  begin legal = 1'b0; dec_idx = 4'd0; end
      endcase
    end else begin
      succ = {code_in[0], code_in[4:1]};
      case (code_in)
        5'b00001: begin legal = 1'b1; dec_idx = 4'd0; end
        5'b00010: begin legal = 1'b1; dec_idx = 4'd1; end
        5'b00100: begin legal = 1'b1; dec_idx = 4'd2; end
        5'b01000: begin legal = 1'b1; dec_idx = 4'd3; end
        5'b10000: begin legal = 1'b1; dec_idx = 4'd4; end
        default:  begin legal = 1'b0; dec_idx = 4'd0; end
      endcase
    end
  end

  // Lock FSM next-state, expected code, counters and pulse outputs.
  always_comb begin
    state_n       = state;
    expected_n    = expected;
    match_n       = match_cnt;
    miss_n        = miss_cnt;
    index_n       = index;
    index_valid_n = 1'b0;
    seq_err_n     = 1'b0;
    illegal_n     = 1'b0;
    err_inc       = 1'b0;

    // Decode of the sampled code is common to every state.
    if (code_valid) begin
      if (legal) begin
        index_n       = dec_idx;
        index_valid_n = 1'b1;
      end else begin
        illegal_n = 1'b1;
        err_inc   = 1'b1;
      end
    end

    if (mode_chg) begin
      // Family switch: drop all sequence history; SEARCH re-seeds expected anyway.
      state_n = SEARCH;
      match_n = 4'd0;
      miss_n  = 2'd0;
    end else if (code_valid) begin
      case (state)
        SEARCH: begin
          if (legal) begin
            expected_n = succ;
            match_n    = 4'd0;
            state_n    = CHECK;
          end
        end
        CHECK: begin
          if (!legal) begin
            state_n = SEARCH;
            match_n = 4'd0;
          end else if (code_in == expected) begin
            match_n    = match_cnt + 4'd1;
            expected_n = succ;
            if (match_cnt + 4'd1 == LOCK_TGT) begin
              state_n = LOCKED;
              miss_n  = 2'd0;
            end
          end else begin
            expected_n = succ;
            match_n    = 4'd0;
          end
        end
        LOCKED: begin
          if (legal && code_in == expected) begin
            miss_n     = 2'd0;
            expected_n = succ;
          end else begin
            if (legal) begin
              seq_err_n  = 1'b1;
              err_inc    = 1'b1;
              expected_n = succ;
            end
            // Two misses in a row means the stream is no longer trustworthy.
            if (miss_cnt != 2'd0) begin
              state_n = SEARCH;
              miss_n  = 2'd0;
              match_n = 4'd0;
            end else begin
              miss_n = miss_cnt + 2'd1;
            end
          end
        end
        default: begin
          state_n = SEARCH;
          match_n = 4'd0;
          miss_n  = 2'd0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SEARCH;
      expected    <= 5'b00000;
      match_cnt   <= 4'd0;
      miss_cnt    <= 2'd0;
      mode_q      <= 1'b0;
      index       <= 4'd0;
      index_valid <= 1'b0;
      locked      <= 1'b0;
      seq_err     <= 1'b0;
      illegal     <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_n;
      expected    <= expected_n;
      match_cnt   <= match_n;
      miss_cnt    <= miss_n;
      mode_q      <= mode;
      index       <= index_n;
      index_valid <= index_valid_n;
      locked      <= (state_n == LOCKED);
      seq_err     <= seq_err_n;
      illegal     <= illegal_n;
      if (err_inc && (err_count != {ERR_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_combined_counter_decoder.sv
// Directed bench for combined_counter_decoder: Johnson lock/wrap, skip, illegal
// unlock, ring with gaps and mode switch, error saturation and async reset.
module tb_combined_counter_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic [4:0] code_in = 5'b00000;
  logic       code_valid = 1'b0;

  logic [3:0] index;
  logic       index_valid, locked, seq_err, illegal;
  logic [7:0] err_count;

  logic [3:0] s_index;
  logic       s_index_valid, s_locked, s_seq_err, s_illegal;
  logic [1:0] s_err_count;

  int vectors = 0;
  int miscompares = 0;

  logic [4:0] jc [10];

  always #5 clk = ~clk;

  combined_counter_decoder #(.LOCK_CNT(3), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .code_in(code_in), .code_valid(code_valid),
    .index(index), .index_valid(index_valid), .locked(locked),
    .seq_err(seq_err), .illegal(illegal), .err_count(err_count)
  );

  combined_counter_decoder #(.LOCK_CNT(3), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mode(mode), .code_in(code_in), .code_valid(code_valid),
    .index(s_index), .index_valid(s_index_valid), .locked(s_locked),
    .seq_err(s_seq_err), .illegal(s_illegal), .err_count(s_err_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Drive one cycle at the falling edge, then settle just after the rising edge.
  task automatic step(input logic vld, input logic [4:0] code);
    @(negedge clk);
    code_valid = vld;
    code_in    = code;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    code_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    jc[0] = 5'b00000; jc[1] = 5'b10000; jc[2] = 5'b11000; jc[3] = 5'b11100;
    jc[4] = 5'b11110; jc[5] = 5'b11111; jc[6] = 5'b01111; jc[7] = 5'b00111;
    jc[8] = 5'b00011; jc[9] = 5'b00001;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_index", 32'(index), 0);
    chk("rst_ivld", 32'(index_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_seqerr", 32'(seq_err), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Johnson lock and wrap: locked after the 4th code, index wraps 9->0.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, jc[i % 10]);
      chk($sformatf("jn_index%0d", i), 32'(index), 32'(i % 10));
      chk($sformatf("jn_ivld%0d", i), 32'(index_valid), 1);
      chk($sformatf("jn_locked%0d", i), 32'(locked), (i >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("jn_seqerr%0d", i), 32'(seq_err), 0);
    end

    // Skip while locked: expected 11000, send 11100.
    step(1'b1, 5'b11100);
    chk("skip_seqerr", 32'(seq_err), 1);
    chk("skip_errcnt", 32'(err_count), 1);
    chk("skip_locked", 32'(locked), 1);
    chk("skip_index", 32'(index), 3);
    step(1'b1, 5'b11110);
    chk("skip_next_seqerr", 32'(seq_err), 0);
    chk("skip_next_errcnt", 32'(err_count), 1);
    chk("skip_next_index", 32'(index), 4);
    chk("skip_next_locked", 32'(locked), 1);

    // Illegal code twice while locked unlocks, index held.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, jc[i]);
    chk("ill_prelock", 32'(locked), 1);
    step(1'b1, 5'b10101);
    chk("ill1_illegal", 32'(illegal), 1);
    chk("ill1_ivld", 32'(index_valid), 0);
    chk("ill1_errcnt", 32'(err_count), 1);
    chk("ill1_locked", 32'(locked), 1);
    chk("ill1_index", 32'(index), 3);
    step(1'b1, 5'b10101);
    chk("ill2_illegal", 32'(illegal), 1);
    chk("ill2_errcnt", 32'(err_count), 2);
    chk("ill2_locked", 32'(locked), 0);
    chk("ill2_index", 32'(index), 3);
    step(1'b0, 5'b10101);
    chk("idle_illegal", 32'(illegal), 0);
    chk("idle_ivld", 32'(index_valid), 0);
    chk("idle_errcnt", 32'(err_count), 2);

    // Ring with gaps, then mode switch drops lock.
    do_reset();
    @(negedge clk);
    mode = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 5'b10000);
    chk("ring0_index", 32'(index), 4);
    step(1'b0, 5'b00000);
    chk("ring_gap_ivld", 32'(index_valid), 0);
    chk("ring_gap_index", 32'(index), 4);
    step(1'b1, 5'b01000);
    chk("ring1_index", 32'(index), 3);
    step(1'b0, 5'b00000);
    step(1'b1, 5'b00100);
    chk("ring2_index", 32'(index), 2);
    chk("ring2_locked", 32'(locked), 0);
    step(1'b0, 5'b00000);
    step(1'b1, 5'b00010);
    chk("ring3_index", 32'(index), 1);
    chk("ring3_locked", 32'(locked), 1);
    step(1'b0, 5'b00000);
    chk("ring_gap_locked", 32'(locked), 1);
    @(negedge clk);
    mode = 1'b0;
    @(posedge clk);
    #1;
    chk("modesw_locked", 32'(locked), 0);

    // Saturation: 5 illegal codes, narrow counter stops at 3.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 5'b10101);
    chk("sat_errcnt_w2", 32'(s_err_count), 3);
    chk("sat_errcnt_w8", 32'(err_count), 5);
    step(1'b1, 5'b10000);
    chk("sat_legal_index", 32'(index), 1);

    // Asynchronous reset between edges clears outputs before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_index", 32'(index), 0);
    chk("arst_ivld", 32'(index_valid), 0);
    chk("arst_errcnt", 32'(err_count), 0);
    chk("arst_errcnt_w2", 32'(s_err_count), 0);
    chk("arst_locked", 32'(locked), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 5'b11000);
    chk("post_rst_index", 32'(index), 2);
    chk("post_rst_ivld", 32'(index_valid), 1);
    chk("post_rst_errcnt", 32'(err_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
